// File: rtl/light_io_pkg.sv
// light_io_pkg
// Shared constants and helpers for the LED driver blocks.
//   CH_IDX_W      : width of a channel index on the write port
//   pwm_max(w)    : full-scale PWM value for a w-bit counter (2^w - 1)
package light_io_pkg;

    localparam int CH_IDX_W = 4;

    function automatic int pwm_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// edge_sync
// Brings an asynchronous level into the clock domain through two flops and
// emits a one-cycle pulse for each rising edge of the synchronized level.
//   clock    : system clock
//   reset_n  : synchronous active-low reset
//   i_d      : asynchronous input level
//   o_rise   : one-cycle pulse, high in the cycle after the 2nd sync flop
//              first sees the new high level
module edge_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic i_d,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Combinational from flops only: consumers act on the edge that also
    // loads r_s3, so a rise lands on the 3rd edge after it was sampled.
    assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/led_pwm_driver.sv
// led_pwm_driver
// Multi-channel PWM LED driver stepped by a slow divided clock.
//   clock, reset_n : system clock, synchronous active-low reset
//   clock_d        : divided clock (async level); each rise = one PWM step
//   wr_valid/ready : duty write handshake
//   wr_channel     : target channel (out-of-range writes are dropped)
//   wr_duty        : target duty, 0 = off, 2^WIDTH-1 = always on
//   wr_fade        : 1 = ramp one count per period, 0 = jump at boundary
//   led            : registered PWM outputs
//   period_start   : one-cycle pulse when the counter wraps to 0
//   busy           : per channel, active duty still differs from target
module led_pwm_driver
    import light_io_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                clock_d,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [CH_IDX_W-1:0] wr_channel,
    input  logic [WIDTH-1:0]    wr_duty,
    input  logic                wr_fade,
    output logic [CHANNELS-1:0] led,
    output logic                period_start,
    output logic [CHANNELS-1:0] busy
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(pwm_max(WIDTH) - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic             w_step;
    logic             w_wrap;
    logic             w_accept;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic             r_ps;
    logic             r_live;

    edge_sync u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .i_d     (clock_d),
        .o_rise  (w_step)
    );

    // The boundary commit happens on the edge ending this cycle; holding
    // ready low here keeps writes and commits on different edges.
    assign w_wrap   = w_step & (r_cnt == LAST);
    assign wr_ready = r_live & ~w_wrap;
    assign w_accept = wr_valid & wr_ready;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_step) begin
            w_cnt_nxt = w_wrap ? '0 : r_cnt + ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_ps   <= 1'b0;
            r_live <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_ps   <= w_wrap;
            r_live <= 1'b1;
        end
    end

    assign period_start = r_ps;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] r_target;
        logic [WIDTH-1:0] r_active;
        logic             r_fade;
        logic             r_led;
        logic             r_busy;
        logic             w_sel;
        logic [WIDTH-1:0] w_tgt_nxt;
        logic [WIDTH-1:0] w_act_nxt;

        assign w_sel     = w_accept & (wr_channel == CH_IDX_W'(g));
        assign w_tgt_nxt = w_sel ? wr_duty : r_target;

        // Commit reads the current target; a write can never land on the
        // same edge, so there is no bypass to worry about.
        always_comb begin
            w_act_nxt = r_active;
            if (w_wrap) begin
                if (!r_fade) begin
                    w_act_nxt = r_target;
                end else if (r_active < r_target) begin
                    w_act_nxt = r_active + ONE;
                end else if (r_active > r_target) begin
                    w_act_nxt = r_active - ONE;
                end
            end
        end

        // led/busy are computed from next-state values so they register on
        // the same edge as the counter/duty they depend on.
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                r_target <= '0;
                r_active <= '0;
                r_fade   <= 1'b0;
                r_led    <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                r_target <= w_tgt_nxt;
                r_active <= w_act_nxt;
                r_fade   <= w_sel ? wr_fade : r_fade;
                r_led    <= (w_cnt_nxt < w_act_nxt);
                r_busy   <= (w_act_nxt != w_tgt_nxt);
            end
        end

        assign led[g]  = r_led;
        assign busy[g] = r_busy;
    end

endmodule
